muldiv_unit: RTL

Iterative integer multiply/divide unit implementing RV64M and its W-variants. It sits alongside the ALU in the Execute stage and is fed by the already-forwarded operands. It stalls the pipeline through the hazard unit while an operation is in flight. XLEN is parametrised so the same block serves RV32M and RV64M builds.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the M-extension datapath and decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP32   = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide sharing one 2*XLEN accumulator and one down-counter.
//
// state | meaning
// IDLE  | waiting for Start_E; special divides resolve here straight to DONE
// BUSY  | one mul/div iteration per cycle until the counter reaches 0
// DONE  | Done_E high, MulDivResult_E holds the new result
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit W_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start_E,
  input  logic            Flush_E,
  input  logic [2:0]      Op_E,
  input  logic            Word_E,
  input  logic [XLEN-1:0] SrcA_E,
  input  logic [XLEN-1:0] SrcB_E,
  output logic            Stall_E,
  output logic            Done_E,
  output logic [XLEN-1:0] MulDivResult_E
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_WORD = CW'(31);
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_WORD = {{(XLEN-31){1'b1}}, 31'b0};

  function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
    logic [31:0] lo;
    lo = v[31:0];
    return w ? XLEN'(signed'(lo)) : v;
  endfunction

  muldiv_state_t   state_q;
  muldiv_op_t      op_q;
  logic            word_q;
  logic            neg_res_q;
  logic            neg_rem_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mag_b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;

  // ---------------- operand preparation (IDLE) ----------------
  muldiv_op_t      op_in;
  logic            word_in;
  logic            ext_signed;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] min_val;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign op_in      = muldiv_op_t'(Op_E);
  assign word_in    = W_EN & Word_E;
  // DIVUW/REMUW zero-extend their 32-bit operands, all other W-ops sign-extend
  assign ext_signed = ~(Op_E[2] & Op_E[0]);

  assign a_ext = word_in ? (ext_signed ? XLEN'(signed'(SrcA_E[31:0])) : XLEN'(SrcA_E[31:0]))
                         : SrcA_E;
  assign b_ext = word_in ? (ext_signed ? XLEN'(signed'(SrcB_E[31:0])) : XLEN'(SrcB_E[31:0]))
                         : SrcB_E;

  assign a_signed = word_in ? ext_signed
                            : (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign b_signed = word_in ? ext_signed
                            : (op_in inside {OP_MULH, OP_DIV, OP_REM});

  assign a_neg = a_signed & a_ext[XLEN-1];
  assign b_neg = b_signed & b_ext[XLEN-1];
  assign mag_a = a_neg ? -a_ext : a_ext;
  assign mag_b = b_neg ? -b_ext : b_ext;

  assign min_val  = word_in ? MIN_WORD : MIN_FULL;
  assign div_zero = Op_E[2] & (b_ext == '0);
  assign div_ovf  = Op_E[2] & ~Op_E[0] & (a_ext == min_val) & (b_ext == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = Op_E[1] ? a_ext : '1;
    else          special_res = Op_E[1] ? '0 : a_ext;
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh, rem_sub;
  logic              q_bit;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  // Remainder stays below the divisor, so rem_sh - divisor always fits XLEN+1 bits
  assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign rem_sub = rem_sh - {1'b0, mag_b_q};
  assign q_bit   = ~rem_sub[XLEN];
  assign rem_new = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_nxt = {rem_new, acc_q[XLEN-2:0], q_bit};

  assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;

  // ---------------- final result from the last step ----------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   res_full;

  // A W-multiply runs only 32 steps, leaving the product 32 bits short of fully shifted
  assign prod   = word_q ? (acc_nxt >> (XLEN - 32)) : acc_nxt;
  assign prod_s = neg_res_q ? -prod : prod;
  assign quo_s  = neg_res_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem_s  = neg_rem_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    res_full = '0;
    case (op_q)
      OP_MUL:                       res_full = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_full = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_full = quo_s;
      OP_REM, OP_REMU:              res_full = rem_s;
      default:                      res_full = '0;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else if (Flush_E) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start_E) begin
            op_q      <= op_in;
            word_q    <= word_in;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            mag_b_q   <= mag_b;
            if (special) begin
              result_q <= fix_word(word_in, special_res);
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              cnt_q   <= word_in ? CNT_WORD : CNT_FULL;
              // divide shifts the dividend out from the top, so W-ops start left-aligned
              acc_q   <= {{XLEN{1'b0}},
                          (Op_E[2] && word_in) ? (mag_a << (XLEN - 32)) : mag_a};
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_nxt;
          if (cnt_q == '0) begin
            result_q <= fix_word(word_q, res_full);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Stall_E        = ((state_q == IDLE) & Start_E) | (state_q == BUSY);
  assign Done_E         = done_q;
  assign MulDivResult_E = result_q;

endmodule
